control_unit: RTL and testbench

CONTROL_UNIT -- requirements
Module: control_unit

---
 rtl/control_unit_if.sv | 30 +++
 rtl/control_unit.sv | 144 ++++++++++++++
 tb/tb_control_unit.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/control_unit_if.sv
// Bundle between the control unit, the instruction ROM and the datapath.
// The master side is the control unit. The slave side is the ROM and datapath, or a bench.
interface control_unit_if #(
    parameter int unsigned PC_W = 7
);
    logic [15:0]     Instr;
    logic [PC_W-1:0] PC_Addr;
    logic [7:0]      D_Addr;
    logic            D_Wr;
    logic            RF_s;
    logic [3:0]      RF_W_Addr;
    logic            RF_W_en;
    logic [3:0]      RF_Ra_Addr;
    logic [3:0]      RF_Rb_Addr;
    logic [2:0]      ALU_s0;
    logic [3:0]      State;
    logic            Halted;

    modport master (
        input  Instr,
        output PC_Addr, D_Addr, D_Wr, RF_s, RF_W_Addr, RF_W_en,
        output RF_Ra_Addr, RF_Rb_Addr, ALU_s0, State, Halted
    );

    modport slave (
        output Instr,
        input  PC_Addr, D_Addr, D_Wr, RF_s, RF_W_Addr, RF_W_en,
        input  RF_Ra_Addr, RF_Rb_Addr, ALU_s0, State, Halted
    );
endinterface

// File: rtl/control_unit.sv
// Multi-cycle Moore control unit with fetch, decode and execute phases for a 16-bit load/store/ALU ISA.
// All outputs come from the registered state and IR, so nothing combinational runs from Instr to an output.
module control_unit #(
    parameter int unsigned PC_W = 7
) (
    input  logic           Clock,
    input  logic           Reset_n,
    control_unit_if.master bus
);
    typedef enum logic [3:0] {
        StInit   = 4'd0,
        StFetch  = 4'd1,
        StDecode = 4'd2,
        StNoop   = 4'd3,
        StLoadA  = 4'd4,
        StLoadB  = 4'd5,
        StStore  = 4'd6,
        StAdd    = 4'd7,
        StSub    = 4'd8,
        StHalt   = 4'd9
    } state_e;

    localparam logic [3:0] OpLoad  = 4'h1;
    localparam logic [3:0] OpStore = 4'h2;
    localparam logic [3:0] OpAdd   = 4'h3;
    localparam logic [3:0] OpSub   = 4'h4;
    localparam logic [3:0] OpHalt  = 4'h5;

    localparam logic [2:0] AluPass = 3'b000;
    localparam logic [2:0] AluAdd  = 3'b001;
    localparam logic [2:0] AluSub  = 3'b010;

    state_e          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [15:0]     ir_q, ir_d;

    logic [7:0] d_addr;
    logic       d_wr;
    logic       rf_s;
    logic [3:0] rf_w_addr;
    logic       rf_w_en;
    logic [3:0] rf_ra_addr;
    logic [3:0] rf_rb_addr;
    logic [2:0] alu_s0;
    logic       halted;

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= StInit;
            pc_q    <= '0;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
        end
    end

    // Instr is looked at only in DECODE, which is the cycle after FETCH put the PC on the ROM.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        case (state_q)
            StInit:   state_d = StFetch;
            StFetch:  state_d = StDecode;
            StDecode: begin
                ir_d = bus.Instr;
                pc_d = pc_q + PC_W'(1);
                case (bus.Instr[15:12])
                    OpLoad:  state_d = StLoadA;
                    OpStore: state_d = StStore;
                    OpAdd:   state_d = StAdd;
                    OpSub:   state_d = StSub;
                    OpHalt:  state_d = StHalt;
                    default: state_d = StNoop;
                endcase
            end
            StLoadA:  state_d = StLoadB;
            StNoop, StLoadB, StStore, StAdd, StSub: state_d = StFetch;
            StHalt:   state_d = StHalt;
            default:  state_d = StInit;
        endcase
    end

    always_comb begin
        d_addr     = '0;
        d_wr       = 1'b0;
        rf_s       = 1'b0;
        rf_w_addr  = '0;
        rf_w_en    = 1'b0;
        rf_ra_addr = '0;
        rf_rb_addr = '0;
        alu_s0     = AluPass;
        halted     = 1'b0;
        case (state_q)
            StLoadA, StLoadB: begin
                d_addr    = ir_q[11:4];
                rf_s      = 1'b1;
                rf_w_addr = ir_q[3:0];
                // LOAD_A only covers the memory read latency; the write happens in LOAD_B
                rf_w_en   = (state_q == StLoadB);
            end
            StStore: begin
                d_addr     = ir_q[11:4];
                rf_ra_addr = ir_q[3:0];
                d_wr       = 1'b1;
            end
            StAdd, StSub: begin
                rf_ra_addr = ir_q[11:8];
                rf_rb_addr = ir_q[7:4];
                rf_w_addr  = ir_q[3:0];
                rf_w_en    = 1'b1;
                alu_s0     = (state_q == StAdd) ? AluAdd : AluSub;
            end
            StHalt:  halted = 1'b1;
            default: ;
        endcase
    end

    assign bus.PC_Addr    = pc_q;
    assign bus.D_Addr     = d_addr;
    assign bus.D_Wr       = d_wr;
    assign bus.RF_s       = rf_s;
    assign bus.RF_W_Addr  = rf_w_addr;
    assign bus.RF_W_en    = rf_w_en;
    assign bus.RF_Ra_Addr = rf_ra_addr;
    assign bus.RF_Rb_Addr = rf_rb_addr;
    assign bus.ALU_s0     = alu_s0;
    assign bus.State      = state_q;
    assign bus.Halted     = halted;

    a_no_dual_write: assert property (@(posedge Clock) disable iff (!Reset_n)
        !(d_wr && rf_w_en));
    a_halt_sticky: assert property (@(posedge Clock) disable iff (!Reset_n)
        state_q == StHalt |=> state_q == StHalt && $stable(pc_q));
    a_load_opcode: assert property (@(posedge Clock) disable iff (!Reset_n)
        (state_q == StLoadA || state_q == StLoadB) |-> ir_q[15:12] == OpLoad);
    a_store_opcode: assert property (@(posedge Clock) disable iff (!Reset_n)
        state_q == StStore |-> ir_q[15:12] == OpStore);
    a_alu_opcode: assert property (@(posedge Clock) disable iff (!Reset_n)
        (state_q == StAdd || state_q == StSub) |->
        ir_q[15:12] == ((state_q == StAdd) ? OpAdd : OpSub));
endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: an instruction-level model expands each ROM program into a per-cycle trace.
// One negedge process compares the DUT against that trace. Literal checks pin the model, the reset behaviour and the halt state.
module tb_control_unit;
    localparam int unsigned PC_W  = 7;
    localparam int unsigned DEPTH = 1 << PC_W;

    typedef struct packed {
        logic [3:0]      state;
        logic [PC_W-1:0] pc;
        logic [7:0]      d_addr;
        logic            d_wr;
        logic            rf_s;
        logic [3:0]      w_addr;
        logic            w_en;
        logic [3:0]      ra;
        logic [3:0]      rb;
        logic [2:0]      alu;
        logic            halted;
    } obs_t;

    logic Clock = 1'b0;
    logic Reset_n;

    control_unit_if #(.PC_W(PC_W)) bus ();

    control_unit #(.PC_W(PC_W)) dut (
        .Clock   (Clock),
        .Reset_n (Reset_n),
        .bus     (bus)
    );

    always #5 Clock = ~Clock;

    logic [15:0] rom [DEPTH];
    always @(posedge Clock) bus.Instr <= rom[bus.PC_Addr];

    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc      = 0;
    bit   checking = 1'b0;
    obs_t exp_q[$];

    task automatic check_eq(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_checks++;
        if (act === expv) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, expv);
    endtask

    function automatic obs_t observe();
        obs_t o;
        o.state  = bus.State;
        o.pc     = bus.PC_Addr;
        o.d_addr = bus.D_Addr;
        o.d_wr   = bus.D_Wr;
        o.rf_s   = bus.RF_s;
        o.w_addr = bus.RF_W_Addr;
        o.w_en   = bus.RF_W_en;
        o.ra     = bus.RF_Ra_Addr;
        o.rb     = bus.RF_Rb_Addr;
        o.alu    = bus.ALU_s0;
        o.halted = bus.Halted;
        return o;
    endfunction

    function automatic obs_t rec(input logic [3:0] st, input int unsigned pc);
        obs_t r;
        r       = '0;
        r.state = st;
        r.pc    = PC_W'(pc);
        return r;
    endfunction

    // Expected per-cycle trace from the start of the first FETCH, one entry per cycle
    task automatic build_trace(input int unsigned n);
        int unsigned pc = 0;
        int unsigned npc;
        bit          hlt = 1'b0;
        logic [15:0] ins;
        obs_t        r;
        exp_q.delete();
        while (exp_q.size() < n) begin
            if (hlt) begin
                r = rec(4'd9, pc);
                r.halted = 1'b1;
                exp_q.push_back(r);
            end else begin
                ins = rom[pc];
                npc = (pc + 1) % DEPTH;
                exp_q.push_back(rec(4'd1, pc));
                exp_q.push_back(rec(4'd2, pc));
                case (ins[15:12])
                    4'h1: begin
                        r        = rec(4'd4, npc);
                        r.d_addr = ins[11:4];
                        r.rf_s   = 1'b1;
                        r.w_addr = ins[3:0];
                        exp_q.push_back(r);
                        r.state  = 4'd5;
                        r.w_en   = 1'b1;
                        exp_q.push_back(r);
                    end
                    4'h2: begin
                        r        = rec(4'd6, npc);
                        r.d_addr = ins[11:4];
                        r.ra     = ins[3:0];
                        r.d_wr   = 1'b1;
                        exp_q.push_back(r);
                    end
                    4'h3, 4'h4: begin
                        r        = rec((ins[15:12] == 4'h3) ? 4'd7 : 4'd8, npc);
                        r.ra     = ins[11:8];
                        r.rb     = ins[7:4];
                        r.w_addr = ins[3:0];
                        r.w_en   = 1'b1;
                        r.alu    = (ins[15:12] == 4'h3) ? 3'b001 : 3'b010;
                        exp_q.push_back(r);
                    end
                    4'h5: hlt = 1'b1;
                    default: exp_q.push_back(rec(4'd3, npc));
                endcase
                pc = npc;
            end
        end
    endtask

    always @(negedge Clock) begin
        if (checking) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL trace underrun at cycle %0d: got state %0d expected a model entry",
                         cyc, bus.State);
            end else begin
                check_eq($sformatf("cycle %0d", cyc), 64'(observe()), 64'(exp_q.pop_front()));
            end
            cyc++;
        end
    end

    // Release reset just after a negedge and compare n cycles
    task automatic run(input int unsigned n);
        @(negedge Clock);
        #1;
        cyc      = 0;
        Reset_n  = 1'b1;
        checking = 1'b1;
        repeat (n) @(negedge Clock);
        #1;
        checking = 1'b0;
    endtask

    task automatic load_prog1();
        for (int i = 0; i < int'(DEPTH); i++) rom[i] = 16'h0000;
        rom[0] = 16'h1A53;
        rom[1] = 16'h2417;
        rom[2] = 16'h3123;
        rom[3] = 16'h4456;
        rom[4] = 16'h5000;
    endtask

    initial begin
        Reset_n = 1'b0;
        load_prog1();
        #2;
        check_eq("reset outputs", 64'(observe()), 64'(rec(4'd0, 0)));

        build_trace(40);
        check_eq("model LOAD_A d_addr", 64'(exp_q[2].d_addr), 64'(8'hA5));
        check_eq("model LOAD_A w_en", 64'(exp_q[2].w_en), 64'(1'b0));
        check_eq("model LOAD_B", 64'(exp_q[3].w_en & exp_q[3].rf_s), 64'(1'b1));
        check_eq("model FETCH after LOAD", 64'(exp_q[4]), 64'(rec(4'd1, 1)));
        check_eq("model STORE", 64'({exp_q[6].d_addr, exp_q[6].ra, exp_q[6].d_wr}),
                 64'({8'h41, 4'd7, 1'b1}));
        check_eq("model ADD", 64'({exp_q[9].ra, exp_q[9].rb, exp_q[9].w_addr, exp_q[9].alu}),
                 64'({4'd1, 4'd2, 4'd3, 3'b001}));
        check_eq("model SUB", 64'({exp_q[12].ra, exp_q[12].rb, exp_q[12].w_addr, exp_q[12].alu}),
                 64'({4'd4, 4'd5, 4'd6, 3'b010}));
        check_eq("model HALT", 64'({exp_q[15].state, exp_q[15].pc, exp_q[15].halted}),
                 64'({4'd9, 7'd5, 1'b1}));
        run(40);
        check_eq("halt held State", 64'(bus.State), 64'(4'd9));
        check_eq("halt held PC_Addr", 64'(bus.PC_Addr), 64'(7'd5));
        check_eq("halt held Halted", 64'(bus.Halted), 64'(1'b1));

        // Reset out of HALT, then a reset dropped into the middle of LOAD_B
        Reset_n = 1'b0;
        #1;
        check_eq("reset leaves halt", 64'(observe()), 64'(rec(4'd0, 0)));
        build_trace(4);
        run(4);
        check_eq("in LOAD_B before reset", 64'({bus.State, bus.RF_W_en}), 64'({4'd5, 1'b1}));
        Reset_n = 1'b0;
        #1;
        check_eq("LOAD_B async reset", 64'(observe()), 64'(rec(4'd0, 0)));
        check_eq("no edge during reset", 64'(Clock), 64'(1'b0));

        build_trace(7);
        run(7);
        check_eq("in STORE before reset", 64'({bus.State, bus.D_Wr}), 64'({4'd6, 1'b1}));
        Reset_n = 1'b0;
        #1;
        check_eq("STORE async reset", 64'(observe()), 64'(rec(4'd0, 0)));
        build_trace(12);
        run(12);

        // Undefined opcode executes as NOOP; NOOPs run the PC round to 0
        Reset_n = 1'b0;
        for (int i = 0; i < int'(DEPTH); i++) rom[i] = 16'h0000;
        rom[0] = 16'hF123;
        build_trace(390);
        check_eq("model undefined op", 64'(exp_q[2]), 64'(rec(4'd3, 1)));
        check_eq("model NOOP latency", 64'(exp_q[3]), 64'(rec(4'd1, 1)));
        check_eq("model NOOP at 127", 64'(exp_q[383]), 64'(rec(4'd3, 0)));
        check_eq("model PC wrap", 64'(exp_q[384]), 64'(rec(4'd1, 0)));
        run(390);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
